// File: rtl/lc3b_types.sv
// Shared LC-3b out-of-order core types: machine word, ROB tag and the CDB broadcast record.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_rob_addr;

    localparam int num_RS_units = 4;
    // ALU reservation-station units plus the multiplier and the divider
    localparam int cdb_num_src  = num_RS_units + 2;

    typedef struct packed {
        logic         valid;
        lc3b_word     data;
        lc3b_rob_addr tag;
    } lc3b_cdb_t;

endpackage

// File: rtl/cdb_arbiter_picker.sv
// N-way one-hot picker: first request at or after start, wrapping modulo N.
// Also suitable for reservation-station issue selection.
module rr_priority_picker #(
    parameter int N  = 6,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    logic [PW-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt = '0;
        vld = |req;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(start) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmitter: one holding slot per producing unit, one registered broadcast per cycle.
// Round-robin by default; CDB_ROB_PRIORITY_EN switches to oldest-ROB-tag-first using rob_head.
module cdb_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_SRC = cdb_num_src,
    parameter int TAG_W   = 3
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC-1:0][15:0]        src_data,
    input  logic [NUM_SRC-1:0][TAG_W-1:0]   src_tag,
    output logic [NUM_SRC-1:0]              src_ready,
`ifdef CDB_ROB_PRIORITY_EN
    input  logic [TAG_W-1:0]                rob_head,
`endif
    output lc3b_cdb_t                       cdb_out
);

    localparam int PW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]            full;
    logic [NUM_SRC-1:0][15:0]      slot_data;
    logic [NUM_SRC-1:0][TAG_W-1:0] slot_tag;
    logic [NUM_SRC-1:0]            pick_gnt;
    logic [NUM_SRC-1:0]            gnt;
    logic [NUM_SRC-1:0]            load;
    logic [PW-1:0]                 g_idx;
    logic                          any_gnt;

`ifdef CDB_ROB_PRIORITY_EN
    logic [TAG_W-1:0] age;
    logic [TAG_W-1:0] best_age;
    logic             found;

    // Smallest distance from the ROB head is the oldest; strict < keeps the lowest index on ties.
    always_comb begin
        pick_gnt = '0;
        age      = '0;
        best_age = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            age = slot_tag[i] - rob_head;
            if (full[i] && (!found || age < best_age)) begin
                found    = 1'b1;
                best_age = age;
                pick_gnt = '0;
                pick_gnt[i] = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] rr_ptr;
    logic          pick_vld;

    rr_priority_picker #(.N(NUM_SRC)) u_pick (
        .req   (full),
        .start (rr_ptr),
        .gnt   (pick_gnt),
        .vld   (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (any_gnt && pick_vld)
            rr_ptr <= (g_idx == PW'(NUM_SRC - 1)) ? '0 : g_idx + 1'b1;
    end
`endif

    assign gnt       = flush ? '0 : pick_gnt;
    assign any_gnt   = |gnt;
    assign src_ready = (reset_n && !flush) ? (~full | gnt) : '0;
    assign load      = src_valid & src_ready;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (gnt[i]) g_idx = PW'(i);
    end

    // A slot granted and reloaded in the same cycle stays full with the new result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full    <= '0;
            cdb_out <= '0;
        end else if (flush) begin
            full          <= '0;
            cdb_out.valid <= 1'b0;
        end else begin
            full <= (full & ~gnt) | load;
            if (any_gnt)
                cdb_out <= '{1'b1, lc3b_word'(slot_data[g_idx]), lc3b_rob_addr'(slot_tag[g_idx])};
            else
                cdb_out.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (load[i]) begin
                slot_data[i] <= src_data[i];
                slot_tag[i]  <= src_tag[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a slot/queue level model.
module tb_cdb_arbiter;
    import lc3b_types::*;

    localparam int NS = cdb_num_src;
    localparam int TW = 3;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     flush;
    logic [NS-1:0]            src_valid;
    logic [NS-1:0][15:0]      src_data;
    logic [NS-1:0][TW-1:0]    src_tag;
    logic [NS-1:0]            src_ready;
    logic [TW-1:0]            rob_head;
    lc3b_cdb_t                cdb_out;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_SRC(NS), .TAG_W(TW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_tag   (src_tag),
        .src_ready (src_ready),
`ifdef CDB_ROB_PRIORITY_EN
        .rob_head  (rob_head),
`endif
        .cdb_out   (cdb_out)
    );

    // reference model state
    bit          m_full [NS];
    logic [15:0] m_data [NS];
    logic [2:0]  m_tag  [NS];
    int          m_rr;
    logic [19:0] m_cdb;
    logic [NS-1:0] last_acc;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic int m_pick();
        int best = -1;
`ifdef CDB_ROB_PRIORITY_EN
        int bage = 0;
        for (int i = 0; i < NS; i++) begin
            int a = (int'(m_tag[i]) - int'(rob_head) + 8) % 8;
            if (m_full[i] && (best < 0 || a < bage)) begin
                best = i;
                bage = a;
            end
        end
`else
        for (int k = 0; k < NS; k++) begin
            int i = (m_rr + k) % NS;
            if (best < 0 && m_full[i]) best = i;
        end
`endif
        return best;
    endfunction

    function automatic logic [NS-1:0] m_ready();
        logic [NS-1:0] r = '0;
        int g;
        if (!reset_n || flush) return r;
        g = m_pick();
        for (int i = 0; i < NS; i++) r[i] = !m_full[i] || (i == g);
        return r;
    endfunction

    // One clock: check ready, advance the model, check the broadcast.
    task automatic cycle(input string nm);
        logic [NS-1:0] r;
        logic [NS-1:0] acc;
        int g;
        #1;
        r = m_ready();
        check({nm, "/ready"}, 32'(src_ready), 32'(r));
        g   = m_pick();
        acc = src_valid & r;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) m_full[i] = 0;
            m_rr  = 0;
            m_cdb = '0;
        end else if (flush) begin
            for (int i = 0; i < NS; i++) m_full[i] = 0;
            m_cdb[19] = 1'b0;
        end else begin
            if (g >= 0) begin
                m_cdb     = {1'b1, m_data[g], m_tag[g]};
                m_full[g] = 0;
                m_rr      = (g + 1) % NS;
            end else begin
                m_cdb[19] = 1'b0;
            end
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) begin
                    m_full[i] = 1;
                    m_data[i] = src_data[i];
                    m_tag[i]  = src_tag[i];
                end
            end
        end
        check({nm, "/cdb"}, {12'h0, cdb_out}, {12'h0, m_cdb});
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic idle();
        src_valid = '0;
        src_data  = '0;
        src_tag   = '0;
    endtask

    task automatic present(input int i, input logic [15:0] d, input logic [2:0] t);
        src_valid[i] = 1'b1;
        src_data[i]  = d;
        src_tag[i]   = t;
    endtask

    bit          pend  [NS];
    logic [15:0] pdata [NS];
    logic [2:0]  ptag  [NS];

    initial begin
        reset_n  = 1'b0;
        flush    = 1'b0;
        rob_head = '0;
        m_rr     = 0;
        m_cdb    = '0;
        for (int i = 0; i < NS; i++) begin
            m_full[i] = 0;
            pend[i]   = 0;
        end
        idle();
        @(negedge clk);

        // reset state
        cycle("reset");
        cycle("reset");
        reset_n = 1'b1;
        cycle("post_reset");

        // single source
        present(2, 16'h1234, 3'd5);
        cycle("single_load");
        idle();
        cycle("single_bcast");
        check("single_value", {12'h0, cdb_out}, {12'h0, 1'b1, 16'h1234, 3'd5});
        cycle("single_drop");
        check("single_valid_low", 32'(cdb_out.valid), 32'd0);

        // all six at once, from a fresh pointer
        reset_n = 1'b0;
        cycle("all_reset");
        reset_n = 1'b1;
        for (int i = 0; i < NS; i++) present(i, 16'(i << 4), 3'(i));
        cycle("all_load");
        idle();
        for (int i = 0; i < NS; i++) begin
            cycle("all_bcast");
            check("all_order", 32'(cdb_out.tag), 32'(i));
        end
        cycle("all_drain");

        // back-to-back from source 4
        for (int k = 0; k < 10; k++) begin
            idle();
            present(4, 16'($urandom), 3'(k));
            cycle("stream");
        end
        idle();
        cycle("stream_tail");
        cycle("stream_idle");

        // flush with three slots full
        present(1, 16'hAAAA, 3'd1);
        present(3, 16'hBBBB, 3'd3);
        present(5, 16'hCCCC, 3'd6);
        cycle("flush_load");
        idle();
        flush = 1'b1;
        cycle("flush");
        flush = 1'b0;
        cycle("flush_after");
        check("flush_ready_all", 32'(src_ready), 32'({NS{1'b1}}));
        cycle("flush_quiet");

        // reset mid-stream with four slots full
        for (int i = 0; i < 4; i++) present(i + 1, 16'h5000 + 16'(i), 3'(i));
        cycle("rst_load");
        idle();
        reset_n = 1'b0;
        cycle("rst_mid");
        check("rst_mid_zero", {12'h0, cdb_out}, 32'h0);
        reset_n = 1'b1;
        present(3, 16'h0303, 3'd3);
        present(5, 16'h0505, 3'd5);
        cycle("rst_reload");
        idle();
        cycle("rst_first");
`ifdef CDB_ROB_PRIORITY_EN
        check("rst_first_tag", 32'(cdb_out.tag), 32'd3);
`else
        check("rst_first_tag", 32'(cdb_out.tag), 32'd3);
`endif
        cycle("rst_second");

`ifdef CDB_ROB_PRIORITY_EN
        // oldest tag first relative to rob_head
        rob_head = 3'd6;
        present(0, 16'h0100, 3'd1);
        present(3, 16'h0700, 3'd7);
        present(5, 16'h0600, 3'd6);
        cycle("age_load");
        idle();
        cycle("age_1");
        check("age_first", 32'(cdb_out.tag), 32'd6);
        cycle("age_2");
        check("age_second", 32'(cdb_out.tag), 32'd7);
        cycle("age_3");
        check("age_third", 32'(cdb_out.tag), 32'd1);
        rob_head = '0;
`endif

        // random traffic; sources hold their result until accepted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NS; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1;
                    pdata[i] = 16'($urandom);
                    ptag[i]  = 3'($urandom);
                end
                src_valid[i] = pend[i];
                src_data[i]  = pdata[i];
                src_tag[i]   = ptag[i];
            end
            flush    = ($urandom_range(0, 31) == 0);
            reset_n  = !($urandom_range(0, 63) == 0);
            rob_head = 3'($urandom);
            cycle("random");
            for (int i = 0; i < NS; i++) if (last_acc[i]) pend[i] = 0;
        end
        flush   = 1'b0;
        reset_n = 1'b1;
        idle();
        for (int n = 0; n < NS + 1; n++) cycle("drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
